// File: rtl/adc_recep_multicanal.sv
// adc_recep_multicanal: serial receiver for N ADCs that share one chip-select and one capture clock.
// Each frame is a run of header zeros followed by data bits, MSB first, sampled while CS is low.
// Frames are started by inicio_rx, or back-to-back while continuo is high. A CS-high guard gap
// follows each frame. Every completed frame produces one packed word plus a 1-cycle rx_listo.
// Optional build macro ADC_VERIF_CERO_EN adds error_cero, which flags a nonzero header per channel.

module adc_recep_multicanal #(
   parameter int unsigned N_CANALES  = 2,
   parameter int unsigned BITS_TRAMA = 16,
   parameter int unsigned BITS_DATO  = 12,
   parameter int unsigned GUARDA     = 2
) (
   input  logic                           clk_captura,
   input  logic                           rst,
   input  logic                           inicio_rx,
   input  logic                           continuo,
   input  logic [N_CANALES-1:0]           dato,
   output logic                           CS,
   output logic                           rx_listo,
   output logic                           ocupado,
   output logic [N_CANALES*BITS_DATO-1:0] paquete_bits
`ifdef ADC_VERIF_CERO_EN
   ,
   output logic [N_CANALES-1:0]           error_cero
`endif
);

   localparam int unsigned ANCHO_CNT = $clog2(BITS_TRAMA);
   localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(BITS_TRAMA - 1);
   localparam logic [3:0] GUARDA_ULTIMO = (GUARDA > 0) ? 4'(GUARDA - 1) : 4'd0;

`ifdef ADC_VERIF_CERO_EN
   // The header must be kept to check it, so the whole frame is stored.
   localparam int unsigned ANCHO_SR = BITS_TRAMA;
   // Ones over the header bits; all zero when the frame has no header.
   localparam logic [BITS_TRAMA-1:0] MASCARA_CERO =
      ~BITS_TRAMA'((64'd1 << BITS_DATO) - 64'd1);
`else
   // Header bits fall off the top of the register and are never stored.
   localparam int unsigned ANCHO_SR = BITS_DATO;
`endif

   typedef enum logic [1:0] {
      StReposo,
      StCaptura,
      StEntrega,
      StGuarda
   } estado_e;

   estado_e                        estado_q, estado_d;
   logic [ANCHO_CNT-1:0]           cnt_bit_q, cnt_bit_d;
   logic [3:0]                     cnt_guarda_q, cnt_guarda_d;
   logic                           cs_q, rx_listo_q, ocupado_q;
   logic [ANCHO_SR-1:0]            sr_q [N_CANALES];
   logic [ANCHO_SR-1:0]            sr_d [N_CANALES];
   logic [N_CANALES*BITS_DATO-1:0] paquete_q, paquete_d;
   logic                           ultimo_bit;
`ifdef ADC_VERIF_CERO_EN
   logic [N_CANALES-1:0]           error_cero_q, error_cero_d;
`endif

   assign ultimo_bit = (estado_q == StCaptura) && (cnt_bit_q == CNT_ULTIMO);

   // Next-state logic: frame sequencing, bit counter and guard counter.
   always_comb begin
      estado_d     = estado_q;
      cnt_bit_d    = cnt_bit_q;
      cnt_guarda_d = cnt_guarda_q;
      unique case (estado_q)
         StReposo: begin
            // Start requests are only looked at here; anything seen mid-frame is dropped.
            if (inicio_rx | continuo) begin
               estado_d  = StCaptura;
               cnt_bit_d = '0;
            end
         end
         StCaptura: begin
            cnt_bit_d = cnt_bit_q + ANCHO_CNT'(1);
            if (cnt_bit_q == CNT_ULTIMO) begin
               estado_d  = StEntrega;
               cnt_bit_d = '0;
            end
         end
         StEntrega: begin
            cnt_guarda_d = '0;
            estado_d     = (GUARDA > 0) ? StGuarda : StReposo;
         end
         StGuarda: begin
            cnt_guarda_d = cnt_guarda_q + 4'd1;
            if (cnt_guarda_q == GUARDA_ULTIMO) begin
               estado_d     = StReposo;
               cnt_guarda_d = '0;
            end
         end
         default: begin
            estado_d = StReposo;
         end
      endcase
   end

   // Data path: shift every channel during capture and latch the packet on the last sample.
   always_comb begin
      paquete_d = paquete_q;
`ifdef ADC_VERIF_CERO_EN
      error_cero_d = error_cero_q;
`endif
      for (int c = 0; c < N_CANALES; c++) begin
         sr_d[c] = sr_q[c];
         if (estado_q == StCaptura) begin
            sr_d[c] = (sr_q[c] << 1) | ANCHO_SR'(dato[c]);
         end
         // The packet includes the sample taken on this same edge, hence sr_d.
         if (ultimo_bit) begin
            paquete_d[c*BITS_DATO +: BITS_DATO] = sr_d[c][BITS_DATO-1:0];
`ifdef ADC_VERIF_CERO_EN
            error_cero_d[c] = |(sr_d[c] & MASCARA_CERO);
`endif
         end
      end
   end

   // State, counters and registered control outputs (derived from the state being entered).
   always_ff @(posedge clk_captura or posedge rst) begin
      if (rst) begin
         estado_q     <= StReposo;
         cnt_bit_q    <= '0;
         cnt_guarda_q <= '0;
         cs_q         <= 1'b1;
         rx_listo_q   <= 1'b0;
         ocupado_q    <= 1'b0;
      end else begin
         estado_q     <= estado_d;
         cnt_bit_q    <= cnt_bit_d;
         cnt_guarda_q <= cnt_guarda_d;
         cs_q         <= (estado_d != StCaptura);
         rx_listo_q   <= (estado_d == StEntrega);
         ocupado_q    <= (estado_d != StReposo);
      end
   end

   // Shift registers and the held output packet.
   always_ff @(posedge clk_captura or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < N_CANALES; c++) begin
            sr_q[c] <= '0;
         end
         paquete_q <= '0;
`ifdef ADC_VERIF_CERO_EN
         error_cero_q <= '0;
`endif
      end else begin
         for (int c = 0; c < N_CANALES; c++) begin
            sr_q[c] <= sr_d[c];
         end
         paquete_q <= paquete_d;
`ifdef ADC_VERIF_CERO_EN
         error_cero_q <= error_cero_d;
`endif
      end
   end

   assign CS           = cs_q;
   assign rx_listo     = rx_listo_q;
   assign ocupado      = ocupado_q;
   assign paquete_bits = paquete_q;
`ifdef ADC_VERIF_CERO_EN
   assign error_cero   = error_cero_q;
`endif

endmodule

// File: tb/tb_adc_recep_multicanal.sv
// Bench for adc_recep_multicanal: an ADC emulator serialises random or fixed frames whenever CS is
// low, and a scoreboard predicts each packet from the frame contents. Directed scenarios cover
// single-shot, continuous mode, ignored restarts, reset mid-frame and continuo dropping.

`timescale 1ns/1ps

module tb_adc_recep_multicanal;

   localparam int unsigned N_CANALES  = 2;
   localparam int unsigned BITS_TRAMA = 16;
   localparam int unsigned BITS_DATO  = 12;
   localparam int unsigned GUARDA     = 2;
   localparam int unsigned ANCHO_PAQ  = N_CANALES * BITS_DATO;
   localparam int unsigned PERIODO    = BITS_TRAMA + GUARDA + 2;

   typedef struct {
      logic [63:0] paq;
      logic [7:0]  err;
   } esperado_t;

   logic                 clk_captura = 1'b0;
   logic                 rst         = 1'b1;
   logic                 inicio_rx   = 1'b0;
   logic                 continuo    = 1'b0;
   logic [N_CANALES-1:0] dato;
   logic                 CS;
   logic                 rx_listo;
   logic                 ocupado;
   logic [ANCHO_PAQ-1:0] paquete_bits;
`ifdef ADC_VERIF_CERO_EN
   logic [N_CANALES-1:0] error_cero;
`endif

   int n_comp  = 0;
   int n_fallos = 0;
   int n_rx    = 0;
   int ciclo   = 0;
   int huecos[$];
   int rx_ciclos[$];
   esperado_t esperados[$];

   logic [31:0]          trama_fija [N_CANALES];
   logic [31:0]          trama_act  [N_CANALES];
   logic [N_CANALES-1:0] canal_fijo = '0;

   adc_recep_multicanal #(
      .N_CANALES  (N_CANALES),
      .BITS_TRAMA (BITS_TRAMA),
      .BITS_DATO  (BITS_DATO),
      .GUARDA     (GUARDA)
   ) dut (
      .clk_captura  (clk_captura),
      .rst          (rst),
      .inicio_rx    (inicio_rx),
      .continuo     (continuo),
      .dato         (dato),
      .CS           (CS),
      .rx_listo     (rx_listo),
      .ocupado      (ocupado),
      .paquete_bits (paquete_bits)
`ifdef ADC_VERIF_CERO_EN
      ,
      .error_cero   (error_cero)
`endif
   );

   initial forever #5 clk_captura = ~clk_captura;

   task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
      n_comp++;
      if (obs !== esp) begin
         n_fallos++;
         $display("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, esp, $time);
      end
   endtask

   // Reference: data word is the frame modulo 2^BITS_DATO, header error is any bit above it.
   function automatic esperado_t modelo(input logic [31:0] tr [N_CANALES]);
      esperado_t e;
      e.paq = '0;
      e.err = '0;
      for (int c = 0; c < N_CANALES; c++) begin
         longint unsigned v;
         v = 64'(tr[c]);
         e.paq = e.paq | ((v % (64'd1 << BITS_DATO)) << (c * BITS_DATO));
         e.err[c] = (v >> BITS_DATO) != 0;
      end
      return e;
   endfunction

   // ADC emulator and monitor; runs on the falling edge, away from the sampling edge.
   initial begin
      int cs_bajo;
      int cs_alto;
      int idx;
      esperado_t e;
      cs_bajo = 0;
      cs_alto = 0;
      idx     = 0;
      dato    = '0;
      forever begin
         @(negedge clk_captura);
         ciclo++;
         if (rst) begin
            esperados.delete();
            cs_bajo = 0;
            cs_alto = 0;
            idx     = 0;
            dato    = '0;
         end else begin
            if (!CS) begin
               if (cs_alto != 0) huecos.push_back(cs_alto);
               cs_alto = 0;
               cs_bajo++;
            end else begin
               if (cs_bajo != 0) begin
                  comprobar("cs_low_cycles", 64'(cs_bajo), 64'(BITS_TRAMA));
                  comprobar("rx_after_cs_rise", 64'(rx_listo), 64'd1);
               end
               cs_bajo = 0;
               cs_alto++;
            end
            if (rx_listo) begin
               n_rx++;
               rx_ciclos.push_back(ciclo);
               if (esperados.size() == 0) begin
                  comprobar("rx_without_frame", 64'(esperados.size()), 64'd1);
               end else begin
                  e = esperados.pop_front();
                  comprobar("paquete_bits", 64'(paquete_bits), e.paq);
`ifdef ADC_VERIF_CERO_EN
                  comprobar("error_cero", 64'(error_cero), 64'(e.err));
`endif
               end
            end
            if (!CS) begin
               if (idx == 0) begin
                  for (int c = 0; c < N_CANALES; c++) begin
                     trama_act[c] = canal_fijo[c] ? trama_fija[c] :
                                    ($urandom() & 32'((64'd1 << BITS_TRAMA) - 64'd1));
                  end
                  esperados.push_back(modelo(trama_act));
               end
               if (idx < int'(BITS_TRAMA)) begin
                  for (int c = 0; c < N_CANALES; c++) begin
                     dato[c] = trama_act[c][BITS_TRAMA-1-idx];
                  end
               end
               idx++;
            end else begin
               idx  = 0;
               dato = '0;
            end
         end
      end
   end

   task automatic pulso_inicio();
      @(posedge clk_captura);
      #1 inicio_rx = 1'b1;
      @(posedge clk_captura);
      #1 inicio_rx = 1'b0;
   endtask

   task automatic esperar_rx(input int limite, output int ciclos, output logic visto);
      visto  = 1'b0;
      ciclos = 0;
      for (int i = 0; i < limite; i++) begin
         @(negedge clk_captura);
         if (rx_listo === 1'b1) begin
            visto  = 1'b1;
            ciclos = i;
            break;
         end
      end
   endtask

   task automatic esperar_ciclos(input int n);
      repeat (n) @(negedge clk_captura);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   ciclos;
      logic visto;
      int   n0;
      int   h0;
      int   bajos;

      for (int c = 0; c < N_CANALES; c++) trama_fija[c] = '0;

      // Reset values
      repeat (3) @(posedge clk_captura);
      @(negedge clk_captura);
      #1 rst = 1'b0;
      @(negedge clk_captura);
      comprobar("reset_cs", 64'(CS), 64'd1);
      comprobar("reset_rx_listo", 64'(rx_listo), 64'd0);
      comprobar("reset_ocupado", 64'(ocupado), 64'd0);
      comprobar("reset_paquete", 64'(paquete_bits), 64'd0);
`ifdef ADC_VERIF_CERO_EN
      comprobar("reset_error_cero", 64'(error_cero), 64'd0);
`endif

      // Single-shot frame with fixed contents
      canal_fijo    = '1;
      trama_fija[0] = 32'h0ABC;
      trama_fija[1] = 32'h0007;
      n0 = n_rx;
      pulso_inicio();
      esperar_rx(40, ciclos, visto);
      comprobar("t1_rx_seen", 64'(visto), 64'd1);
      comprobar("t1_latency", 64'(ciclos), 64'(BITS_TRAMA));
      comprobar("t1_paquete", 64'(paquete_bits), 64'h007ABC);
      esperar_ciclos(PERIODO + 5);
      comprobar("t1_num_rx", 64'(n_rx - n0), 64'd1);
      comprobar("t1_paquete_held", 64'(paquete_bits), 64'h007ABC);

      // Continuous mode, three frames
      canal_fijo    = 2'b01;
      trama_fija[0] = 32'h0FFF;
      huecos.delete();
      rx_ciclos.delete();
      n0 = n_rx;
      @(posedge clk_captura);
      #1 continuo = 1'b1;
      for (int f = 0; f < 3; f++) begin
         esperar_rx(PERIODO + 20, ciclos, visto);
         comprobar("t2_rx_seen", 64'(visto), 64'd1);
         comprobar("t2_ch0_data", 64'(paquete_bits[BITS_DATO-1:0]), 64'hFFF);
      end
      continuo = 1'b0;
      esperar_ciclos(PERIODO + 5);
      comprobar("t2_num_rx", 64'(n_rx - n0), 64'd3);
      comprobar("t2_num_frames", 64'(huecos.size()), 64'd3);
      if (rx_ciclos.size() >= 3) begin
         comprobar("t2_period_1", 64'(rx_ciclos[1] - rx_ciclos[0]), 64'(PERIODO));
         comprobar("t2_period_2", 64'(rx_ciclos[2] - rx_ciclos[1]), 64'(PERIODO));
      end
      if (huecos.size() >= 3) begin
         comprobar("t2_cs_gap_1", 64'(huecos[1]), 64'(GUARDA + 2));
         comprobar("t2_cs_gap_2", 64'(huecos[2]), 64'(GUARDA + 2));
      end

      // Restart request during capture is ignored
      canal_fijo = '0;
      n0 = n_rx;
      h0 = huecos.size();
      pulso_inicio();
      repeat (5) @(posedge clk_captura);
      #1 inicio_rx = 1'b1;
      @(posedge clk_captura);
      #1 inicio_rx = 1'b0;
      esperar_rx(40, ciclos, visto);
      comprobar("t3_rx_seen", 64'(visto), 64'd1);
      esperar_ciclos(PERIODO + 5);
      comprobar("t3_num_rx", 64'(n_rx - n0), 64'd1);
      comprobar("t3_num_frames", 64'(huecos.size() - h0), 64'd1);

      // Reset in the middle of a frame
      n0 = n_rx;
      pulso_inicio();
      repeat (9) @(posedge clk_captura);
      #1 rst = 1'b1;
      #1;
      comprobar("t4_cs_async", 64'(CS), 64'd1);
      comprobar("t4_paquete_cleared", 64'(paquete_bits), 64'd0);
      comprobar("t4_ocupado_cleared", 64'(ocupado), 64'd0);
      @(negedge clk_captura);
      #1 rst = 1'b0;
      esperar_ciclos(PERIODO + 5);
      comprobar("t4_no_rx", 64'(n_rx - n0), 64'd0);
      n0 = n_rx;
      pulso_inicio();
      esperar_rx(40, ciclos, visto);
      comprobar("t4_clean_rx_seen", 64'(visto), 64'd1);
      comprobar("t4_clean_latency", 64'(ciclos), 64'(BITS_TRAMA));
      esperar_ciclos(PERIODO + 5);
      comprobar("t4_clean_num_rx", 64'(n_rx - n0), 64'd1);

`ifdef ADC_VERIF_CERO_EN
      // Nonzero header on channel 1 only
      canal_fijo    = '1;
      trama_fija[0] = 32'h0123;
      trama_fija[1] = 32'h4567;
      pulso_inicio();
      esperar_rx(40, ciclos, visto);
      comprobar("t5_rx_seen", 64'(visto), 64'd1);
      comprobar("t5_error_cero", 64'(error_cero), 64'b10);
      comprobar("t5_paquete", 64'(paquete_bits), 64'h567123);
      esperar_ciclos(PERIODO + 5);
      canal_fijo = '0;
`endif

      // continuo dropped during capture: the frame completes, then the block idles
      n0 = n_rx;
      @(posedge clk_captura);
      #1 continuo = 1'b1;
      bajos = 0;
      for (int i = 0; i < 40 && bajos < 3; i++) begin
         @(negedge clk_captura);
         if (!CS) bajos++;
      end
      continuo = 1'b0;
      esperar_rx(40, ciclos, visto);
      comprobar("t6_rx_seen", 64'(visto), 64'd1);
      for (int g = 0; g < int'(GUARDA); g++) begin
         @(negedge clk_captura);
         comprobar("t6_ocupado_guard", 64'(ocupado), 64'd1);
      end
      @(negedge clk_captura);
      comprobar("t6_ocupado_idle", 64'(ocupado), 64'd0);
      comprobar("t6_cs_idle", 64'(CS), 64'd1);
      esperar_ciclos(PERIODO + 5);
      comprobar("t6_num_rx", 64'(n_rx - n0), 64'd1);
      comprobar("t6_cs_stays_high", 64'(CS), 64'd1);

      // inicio_rx and continuo together for one edge
      n0 = n_rx;
      @(posedge clk_captura);
      #1 inicio_rx = 1'b1;
      continuo = 1'b1;
      @(posedge clk_captura);
      #1 inicio_rx = 1'b0;
      continuo = 1'b0;
      esperar_rx(40, ciclos, visto);
      comprobar("t7_rx_seen", 64'(visto), 64'd1);
      esperar_ciclos(PERIODO + 5);
      comprobar("t7_num_rx", 64'(n_rx - n0), 64'd1);

      // Random single-shot frames with random idle gaps
      for (int k = 0; k < 8; k++) begin
         esperar_ciclos(int'($urandom_range(0, 5)));
         pulso_inicio();
         esperar_rx(40, ciclos, visto);
         comprobar("t8_rx_seen", 64'(visto), 64'd1);
         comprobar("t8_latency", 64'(ciclos), 64'(BITS_TRAMA));
         esperar_ciclos(GUARDA + 2);
      end
      esperar_ciclos(5);
      comprobar("scoreboard_empty", 64'(esperados.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_comp, n_fallos);
      $finish;
   end

endmodule
